// File: rtl/branch_predictor_if.sv
// Fetch-lookup / execute-training bundle between the pipeline and the branch predictor.
// The predictor connects through the slave modport; the pipeline drives it through master.
interface branch_predictor_if;
    logic [31:0] pc_IF;
    logic        predict;
    logic        update_en;
    logic [31:0] pc_EX;
    logic        taken_EX;
    logic        predict_EX;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    modport master (
        output pc_IF, update_en, pc_EX, taken_EX, predict_EX,
        input  predict, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  pc_IF, update_en, pc_EX, taken_EX, predict_EX,
        output predict, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal predictor: flop array of 2-bit saturating counters, combinational lookup on pc_IF.
// Define BP_STATS_EN to build the resolved-branch / misprediction counters; otherwise they read 0.
module branch_predictor #(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] INIT_CNT   = 2'b01
) (
    input logic                clk,
    input logic                rst,
    branch_predictor_if.slave  bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            table_q [ENTRIES];
    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [1:0]            upd_cnt_q;
    logic [1:0]            upd_cnt_d;

    assign lookup_idx = bp.pc_IF[INDEX_BITS+1:2];
    assign upd_idx    = bp.pc_EX[INDEX_BITS+1:2];
    assign upd_cnt_q  = table_q[upd_idx];

    // No bypass: same-index lookup sees the pre-update counter this cycle.
    assign bp.predict = table_q[lookup_idx][1];

    always_comb begin
        upd_cnt_d = upd_cnt_q;
        if (bp.taken_EX) begin
            if (upd_cnt_q != 2'b11) upd_cnt_d = upd_cnt_q + 2'd1;
        end else begin
            if (upd_cnt_q != 2'b00) upd_cnt_d = upd_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= INIT_CNT;
        end else if (bp.update_en) begin
            table_q[upd_idx] <= upd_cnt_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= 32'h0;
            mispredict_cnt_q <= 32'h0;
        end else if (bp.update_en) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
            if (bp.taken_EX != bp.predict_EX) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    assign bp.branch_cnt     = branch_cnt_q;
    assign bp.mispredict_cnt = mispredict_cnt_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.pc_IF[31:INDEX_BITS+2], bp.pc_IF[1:0],
                              bp.pc_EX[31:INDEX_BITS+2], bp.pc_EX[1:0]};
`else
    assign bp.branch_cnt     = 32'h0;
    assign bp.mispredict_cnt = 32'h0;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.pc_IF[31:INDEX_BITS+2], bp.pc_IF[1:0],
                              bp.pc_EX[31:INDEX_BITS+2], bp.pc_EX[1:0], bp.predict_EX};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor: each row is one clock cycle of stimulus with
// the expected pre-edge outputs, pushed to a scoreboard and compared before the next edge.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_predictor_if bp();

    branch_predictor #(.INDEX_BITS(6), .INIT_CNT(2'b01)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    typedef struct {
        logic        r;
        logic        u;
        logic [31:0] pe;
        logic        tk;
        logic        px;
        logic [31:0] pi;
        logic        ep;
        logic [31:0] ebc;
        logic [31:0] emc;
    } vec_t;

    typedef struct {
        logic        p;
        logic [31:0] bc;
        logic [31:0] mc;
        int          id;
    } exp_t;

    localparam int NV = 28;
    vec_t vecs [NV];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] stat(input logic [31:0] x);
`ifdef BP_STATS_EN
        return x;
`else
        return 32'h0;
`endif
    endfunction

    function automatic vec_t mk(input logic r, input logic u, input logic [31:0] pe,
                                input logic tk, input logic px, input logic [31:0] pi,
                                input logic ep, input logic [31:0] ebc, input logic [31:0] emc);
        vec_t v;
        v.r = r; v.u = u; v.pe = pe; v.tk = tk; v.px = px; v.pi = pi;
        v.ep = ep; v.ebc = ebc; v.emc = emc;
        return v;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (bp.predict !== e.p) begin
            errors++;
            $display("FAIL predict row %0d: got %b expected %b (pc_IF=%h)", e.id, bp.predict, e.p, bp.pc_IF);
        end
        checks++;
        if (bp.branch_cnt !== e.bc) begin
            errors++;
            $display("FAIL branch_cnt row %0d: got %0d expected %0d", e.id, bp.branch_cnt, e.bc);
        end
        checks++;
        if (bp.mispredict_cnt !== e.mc) begin
            errors++;
            $display("FAIL mispredict_cnt row %0d: got %0d expected %0d", e.id, bp.mispredict_cnt, e.mc);
        end
    endtask

    task automatic apply(input vec_t v, input int id);
        exp_t e;
        @(negedge clk);
        rst           = v.r;
        bp.update_en  = v.u;
        bp.pc_EX      = v.pe;
        bp.taken_EX   = v.tk;
        bp.predict_EX = v.px;
        bp.pc_IF      = v.pi;
        e.p  = v.ep;
        e.bc = stat(v.ebc);
        e.mc = stat(v.emc);
        e.id = id;
        sb.push_back(e);
        #2;
        check_out();
    endtask

    initial begin
        // Training / saturation / aliasing / hazard / reset-priority / stats rows.
        // Expected outputs are the pre-edge values for that cycle.
        vecs[0]  = mk(0, 1, 32'h10,  1, 0, 32'h10, 0, 0, 0);
        vecs[1]  = mk(0, 1, 32'h10,  1, 1, 32'h10, 1, 1, 1);
        vecs[2]  = mk(0, 1, 32'h10,  1, 1, 32'h10, 1, 2, 1);
        vecs[3]  = mk(0, 0, 32'h10,  1, 1, 32'h10, 1, 3, 1);
        vecs[4]  = mk(0, 1, 32'h10,  0, 1, 32'h10, 1, 3, 1);
        vecs[5]  = mk(0, 1, 32'h10,  0, 1, 32'h10, 1, 4, 2);
        vecs[6]  = mk(0, 0, 32'h10,  0, 0, 32'h10, 0, 5, 3);
        vecs[7]  = mk(0, 1, 32'h10,  0, 0, 32'h10, 0, 5, 3);
        vecs[8]  = mk(0, 1, 32'h10,  0, 0, 32'h10, 0, 6, 3);
        vecs[9]  = mk(0, 1, 32'h10,  1, 0, 32'h10, 0, 7, 3);
        vecs[10] = mk(0, 0, 32'h10,  0, 0, 32'h10, 0, 8, 4);
        vecs[11] = mk(0, 1, 32'h110, 1, 0, 32'h14, 0, 8, 4);
        vecs[12] = mk(0, 1, 32'h110, 1, 1, 32'h10, 1, 9, 5);
        vecs[13] = mk(0, 0, 32'h110, 1, 1, 32'h14, 0, 10, 5);
        vecs[14] = mk(0, 0, 32'h110, 1, 1, 32'h10, 1, 10, 5);
        vecs[15] = mk(0, 1, 32'h20,  1, 0, 32'h20, 0, 10, 5);
        vecs[16] = mk(0, 0, 32'h20,  0, 0, 32'h20, 1, 11, 6);
        vecs[17] = mk(1, 1, 32'h20,  1, 0, 32'h20, 1, 11, 6);
        vecs[18] = mk(0, 0, 32'h20,  0, 0, 32'h20, 0, 0, 0);
        vecs[19] = mk(0, 0, 32'h20,  0, 0, 32'h10, 0, 0, 0);
        vecs[20] = mk(0, 1, 32'h40,  1, 0, 32'h80, 0, 0, 0);
        vecs[21] = mk(0, 1, 32'h40,  1, 1, 32'h80, 0, 1, 1);
        vecs[22] = mk(0, 1, 32'h40,  0, 0, 32'h80, 0, 2, 1);
        vecs[23] = mk(0, 1, 32'h40,  0, 1, 32'h80, 0, 3, 1);
        vecs[24] = mk(0, 1, 32'h40,  1, 1, 32'h80, 0, 4, 2);
        vecs[25] = mk(0, 0, 32'h40,  0, 0, 32'h40, 1, 5, 2);
        vecs[26] = mk(0, 0, 32'h40,  0, 1, 32'h40, 1, 5, 2);
        vecs[27] = mk(0, 0, 32'h44,  0, 0, 32'h40, 1, 5, 2);

        rst           = 1'b1;
        bp.update_en  = 1'b0;
        bp.pc_EX      = 32'h0;
        bp.taken_EX   = 1'b0;
        bp.predict_EX = 1'b0;
        bp.pc_IF      = 32'h0;
        repeat (2) @(posedge clk);

        // Post-reset sweep: every entry must read weakly not-taken.
        for (int a = 0; a < 64; a++)
            apply(mk(0, 0, 32'h0, 0, 0, 32'(a * 4), 0, 0, 0), 100 + a);

        for (int i = 0; i < NV; i++)
            apply(vecs[i], i);

        // Undriven lookup address must not disturb stored state.
        @(negedge clk);
        bp.update_en = 1'b0;
        bp.pc_IF     = 'x;
        apply(mk(0, 0, 32'h0, 0, 0, 32'h40, 1, 5, 2), 200);
        apply(mk(0, 0, 32'h0, 0, 0, 32'h10, 0, 5, 2), 201);

        // Back-to-back reset mid-training: trained entry 16 returns to INIT_CNT.
        apply(mk(1, 0, 32'h0, 0, 0, 32'h40, 1, 5, 2), 202);
        apply(mk(0, 0, 32'h0, 0, 0, 32'h40, 0, 0, 0), 203);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
